// File: rtl/rv_pkg.sv
// Shared types and constants for the RV write-back stage.
package rv_pkg;

  // Write-back source: registered PC+4/ALU result or aligned load data.
  typedef enum logic {
    SEL_PRE  = 1'b0,
    SEL_DMEM = 1'b1
  } t_wb_sel;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic       valid;
    t_wb_sel    sel_wb;
    logic       rf_wr_en;
    logic [4:0] rd_addr;
    logic       dmem_rd_en;
    logic [3:0] dmem_byte_en;
    logic       dmem_sign_ext;
    logic [1:0] addr_lsb;
  } t_wb_ctrl;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } t_wb_state;

  // Halves must not straddle the word; words must be word-aligned.
  function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] lsb);
    return ((be == BE_HALF) && (lsb == 2'b11)) || ((be == BE_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/dff_macros.svh
// Asynchronous active-low reset flop macros.
`ifndef DFF_MACROS_SVH
`define DFF_MACROS_SVH

`define DFF_AR(ck, rn, q, d, rv) \
  always_ff @(posedge ck or negedge rn) begin \
    if (!rn) q <= rv; \
    else q <= d; \
  end

`define DFF_AR_EN(ck, rn, en, q, d, rv) \
  always_ff @(posedge ck or negedge rn) begin \
    if (!rn) q <= rv; \
    else if (en) q <= d; \
  end

`endif

// File: rtl/rv_ld_align.sv
// Load data alignment: shift by byte offset, select width, sign/zero extend.
module rv_ld_align
  import rv_pkg::*;
(
  input  logic [31:0] rsp_data,
  input  logic [3:0]  byte_en,
  input  logic [1:0]  addr_lsb,
  input  logic        sign_ext,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Right-justify the addressed bytes, then extend to 32 bits.
  always_comb begin
    shifted = rsp_data >> {addr_lsb, 3'b000};
    case (byte_en)
      BE_BYTE: ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      BE_HALF: ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/rv_wb.sv
// Write-back stage: load wait FSM, register-file write, forwarding, counters.
`include "dff_macros.svh"

module rv_wb
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  t_wb_ctrl    ctrl,
  input  logic [31:0] pre_wb_data_Q104H,
  input  logic        dmem_rsp_valid_Q104H,
  input  logic [31:0] dmem_rsp_data_Q104H,
  output logic        ready_Q104H,
  output logic        rf_wr_en_Q104H,
  output logic [4:0]  rf_wr_addr_Q104H,
  output logic [31:0] rf_wr_data_Q104H,
  output logic        fwd_valid_Q105H,
  output logic [4:0]  fwd_addr_Q105H,
  output logic [31:0] fwd_data_Q105H,
  output logic        misalign_err_Q104H,
  output logic        spurious_rsp_Q104H,
  output logic [31:0] retired_cnt,
  output logic [15:0] ld_stall_cnt
);

  t_wb_state   state_q, state_d;
  logic        load, stall, commit, misaligned, wr_en;
  logic [31:0] ld_data, wr_data, retired_d;
  logic [15:0] stall_cnt_d;

  rv_ld_align u_ld_align (
    .rsp_data (dmem_rsp_data_Q104H),
    .byte_en  (ctrl.dmem_byte_en),
    .addr_lsb (ctrl.addr_lsb),
    .sign_ext (ctrl.dmem_sign_ext),
    .ld_data  (ld_data)
  );

  // Stall/commit decode and next-state logic; every strobe is gated by rst
  // so the stage looks idle and ready while held in reset.
  always_comb begin
    load       = ctrl.valid & ctrl.dmem_rd_en;
    misaligned = load & is_misaligned(ctrl.dmem_byte_en, ctrl.addr_lsb);
    if (state_q == WB_IDLE) stall = rst & load & ~dmem_rsp_valid_Q104H;
    else                    stall = rst & ~dmem_rsp_valid_Q104H;
    commit  = rst & ~stall;
    wr_en   = commit & ctrl.valid & ctrl.rf_wr_en & (ctrl.rd_addr != 5'd0) & ~misaligned;
    wr_data = (ctrl.sel_wb == SEL_DMEM) ? ld_data : pre_wb_data_Q104H;

    state_d = state_q;
    case (state_q)
      WB_IDLE: if (load && !dmem_rsp_valid_Q104H) state_d = WB_WAIT;
      WB_WAIT: if (dmem_rsp_valid_Q104H)          state_d = WB_IDLE;
      default:                                    state_d = WB_IDLE;
    endcase

    retired_d   = retired_cnt + {31'd0, commit & ctrl.valid};
    stall_cnt_d = (stall && (ld_stall_cnt != 16'hFFFF)) ? ld_stall_cnt + 16'd1 : ld_stall_cnt;
  end

  assign ready_Q104H        = ~stall;
  assign rf_wr_en_Q104H     = wr_en;
  assign rf_wr_addr_Q104H   = ctrl.rd_addr;
  assign rf_wr_data_Q104H   = wr_data;
  assign misalign_err_Q104H = commit & misaligned;
  assign spurious_rsp_Q104H = rst & (state_q == WB_IDLE) & dmem_rsp_valid_Q104H & ~load;

  // FSM state; reset drops any outstanding load.
  `DFF_AR(clk, rst, state_q, state_d, WB_IDLE)

  // Forwarding valid follows the issued write, cleared on idle cycles.
  `DFF_AR(clk, rst, fwd_valid_Q105H, wr_en, 1'b0)

  // Forwarding address captured on each issued write.
  `DFF_AR_EN(clk, rst, wr_en, fwd_addr_Q105H, ctrl.rd_addr, '0)

  // Forwarding data captured on each issued write.
  `DFF_AR_EN(clk, rst, wr_en, fwd_data_Q105H, wr_data, '0)

  // Committed-instruction counter, wraps naturally.
  `DFF_AR(clk, rst, retired_cnt, retired_d, '0)

  // Load stall-cycle counter, saturating.
  `DFF_AR(clk, rst, ld_stall_cnt, stall_cnt_d, '0)

endmodule

// File: tb/tb_rv_wb.sv
// Directed self-checking bench for rv_wb.
module tb_rv_wb;
  import rv_pkg::*;

  logic        clk, rst;
  t_wb_ctrl    ctrl;
  logic [31:0] pre_wb_data, rsp_data;
  logic        rsp_valid;
  logic        ready, wr_en, fwd_valid, mis, spur;
  logic [4:0]  wr_addr, fwd_addr;
  logic [31:0] wr_data, fwd_data, retired;
  logic [15:0] stall_cnt;

  int unsigned n_pass = 0, n_total = 0;
  logic [31:0] exp_ret = 0;

  rv_wb dut (
    .clk                  (clk),
    .rst                  (rst),
    .ctrl                 (ctrl),
    .pre_wb_data_Q104H    (pre_wb_data),
    .dmem_rsp_valid_Q104H (rsp_valid),
    .dmem_rsp_data_Q104H  (rsp_data),
    .ready_Q104H          (ready),
    .rf_wr_en_Q104H       (wr_en),
    .rf_wr_addr_Q104H     (wr_addr),
    .rf_wr_data_Q104H     (wr_data),
    .fwd_valid_Q105H      (fwd_valid),
    .fwd_addr_Q105H       (fwd_addr),
    .fwd_data_Q105H       (fwd_data),
    .misalign_err_Q104H   (mis),
    .spurious_rsp_Q104H   (spur),
    .retired_cnt          (retired),
    .ld_stall_cnt         (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    t_wb_ctrl    c;
    logic [31:0] pre;
    logic        rv;
    logic [31:0] rd;
    logic        e_ready;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_mis;
    logic        e_spur;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic t_wb_ctrl mk(input logic v, input t_wb_sel s, input logic w,
                                  input logic [4:0] rd, input logic ld, input logic [3:0] be,
                                  input logic sx, input logic [1:0] lsb);
    t_wb_ctrl c;
    c.valid = v; c.sel_wb = s; c.rf_wr_en = w; c.rd_addr = rd;
    c.dmem_rd_en = ld; c.dmem_byte_en = be; c.dmem_sign_ext = sx; c.addr_lsb = lsb;
    return c;
  endfunction

  task automatic add(input t_wb_ctrl c, input logic [31:0] pre, input logic rv, input logic [31:0] rd,
                     input logic er, input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic em, input logic es);
    vec_t x;
    x.c = c; x.pre = pre; x.rv = rv; x.rd = rd;
    x.e_ready = er; x.e_wr = ew; x.e_addr = ea; x.e_data = ed; x.e_mis = em; x.e_spur = es;
    vecs.push_back(x);
  endtask

  task automatic drive(input t_wb_ctrl c, input logic [31:0] pre, input logic rv, input logic [31:0] rd);
    ctrl = c; pre_wb_data = pre; rsp_valid = rv; rsp_data = rd;
  endtask

  initial begin
    t_wb_ctrl alu5, ld;
    rst = 1'b0;
    drive('0, 32'd0, 1'b0, 32'd0);

    // Single-cycle vectors, all issued from WB_IDLE.
    add(mk(1, SEL_PRE, 1, 5'd5, 0, 4'b0000, 0, 2'd0), 32'h0000_1234, 0, 32'h0,         1, 1, 5'd5,  32'h0000_1234, 0, 0);
    add(mk(1, SEL_DMEM,1, 5'd6, 1, BE_HALF, 0, 2'd2), 32'h0,         1, 32'hBEEF_0000, 1, 1, 5'd6,  32'h0000_BEEF, 0, 0);
    add(mk(1, SEL_DMEM,1, 5'd7, 1, BE_HALF, 1, 2'd0), 32'h0,         1, 32'h1234_8001, 1, 1, 5'd7,  32'hFFFF_8001, 0, 0);
    add(mk(1, SEL_DMEM,1, 5'd8, 1, BE_BYTE, 0, 2'd3), 32'h0,         1, 32'h8F00_0000, 1, 1, 5'd8,  32'h0000_008F, 0, 0);
    add(mk(1, SEL_DMEM,1, 5'd9, 1, BE_BYTE, 1, 2'd1), 32'h0,         1, 32'h0000_F100, 1, 1, 5'd9,  32'hFFFF_FFF1, 0, 0);
    add(mk(1, SEL_DMEM,1, 5'd10,1, BE_WORD, 1, 2'd0), 32'h0,         1, 32'hDEAD_BEEF, 1, 1, 5'd10, 32'hDEAD_BEEF, 0, 0);
    add(mk(1, SEL_DMEM,1, 5'd11,1, BE_HALF, 0, 2'd3), 32'h0,         1, 32'h1122_3344, 1, 0, 5'd11, 32'h0000_0011, 1, 0);
    add(mk(1, SEL_DMEM,1, 5'd12,1, BE_WORD, 0, 2'd1), 32'h0,         1, 32'hAABB_CCDD, 1, 0, 5'd12, 32'h00AA_BBCC, 1, 0);
    add(mk(1, SEL_PRE, 1, 5'd0, 0, 4'b0000, 0, 2'd0), 32'hFFFF_FFFF, 0, 32'h0,         1, 0, 5'd0,  32'hFFFF_FFFF, 0, 0);
    add(mk(0, SEL_PRE, 1, 5'd3, 0, 4'b0000, 0, 2'd0), 32'h0000_0077, 0, 32'h0,         1, 0, 5'd3,  32'h0000_0077, 0, 0);
    add(mk(0, SEL_PRE, 0, 5'd0, 0, 4'b0000, 0, 2'd0), 32'h0,         1, 32'h5555_5555, 1, 0, 5'd0,  32'h0,         0, 1);
    add(mk(1, SEL_PRE, 0, 5'd4, 0, 4'b0000, 0, 2'd0), 32'h0000_0099, 0, 32'h0,         1, 0, 5'd4,  32'h0000_0099, 0, 0);

    // Reset behaviour with live stimulus on the inputs.
    alu5 = mk(1, SEL_PRE, 1, 5'd5, 0, 4'b0000, 0, 2'd0);
    ld   = mk(1, SEL_DMEM, 1, 5'd5, 1, BE_WORD, 0, 2'd0);
    #2;
    drive(ld, 32'h0, 1'b0, 32'h0);
    #1 chk("rst_ready_on_load", ready, 1);
    drive(alu5, 32'h1234, 1'b0, 32'h0);
    #1 chk("rst_wr_en", wr_en, 0);
    drive(mk(1, SEL_DMEM, 1, 5'd5, 1, BE_WORD, 0, 2'd1), 32'h0, 1'b1, 32'h0);
    #1 chk("rst_misalign", mis, 0);
    drive('0, 32'h0, 1'b1, 32'h0);
    #1 chk("rst_spurious", spur, 0);
    @(posedge clk); #1;
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_addr", fwd_addr, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_retired", retired, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    drive('0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].c, vecs[i].pre, vecs[i].rv, vecs[i].rd);
      #2;
      chk($sformatf("v%0d_ready", i),   ready,   vecs[i].e_ready);
      chk($sformatf("v%0d_wr_en", i),   wr_en,   vecs[i].e_wr);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_data);
      chk($sformatf("v%0d_misalign", i), mis,    vecs[i].e_mis);
      chk($sformatf("v%0d_spurious", i), spur,   vecs[i].e_spur);
      if (vecs[i].c.valid) exp_ret++;
      @(posedge clk); #1;
      chk($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].e_wr);
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d_fwd_addr", i), fwd_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_data);
      end
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, 0);
    end

    // LB, offset 2, signed, response one cycle after entry.
    ld = mk(1, SEL_DMEM, 1, 5'd13, 1, BE_BYTE, 1, 2'd2);
    @(negedge clk); drive(ld, 32'h0, 1'b0, 32'h0);
    #2 chk("lb_entry_ready", ready, 0);
    chk("lb_entry_wr_en", wr_en, 0);
    @(negedge clk); drive(ld, 32'h0, 1'b1, 32'h0080_0000);
    #2 chk("lb_rsp_ready", ready, 1);
    chk("lb_rsp_wr_en", wr_en, 1);
    chk("lb_rsp_wr_data", wr_data, 32'hFFFF_FF80);
    exp_ret++;
    @(posedge clk); #1;
    chk("lb_stall_cnt", stall_cnt, 1);
    chk("lb_fwd_data", fwd_data, 32'hFFFF_FF80);
    chk("lb_retired", retired, exp_ret);

    // LW stalled for three cycles.
    ld = mk(1, SEL_DMEM, 1, 5'd14, 1, BE_WORD, 0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(ld, 32'h0, 1'b0, 32'h0);
      #2 chk($sformatf("lw_wait%0d_ready", k), ready, 0);
    end
    @(negedge clk); drive(ld, 32'h0, 1'b1, 32'hCAFE_F00D);
    #2 chk("lw_rsp_wr_data", wr_data, 32'hCAFE_F00D);
    exp_ret++;
    @(posedge clk); #1;
    chk("lw_stall_cnt", stall_cnt, 4);
    chk("lw_retired", retired, exp_ret);
    chk("lw_fwd_addr", fwd_addr, 14);

    // Reset mid-wait abandons the load; the late response is spurious.
    ld = mk(1, SEL_DMEM, 1, 5'd15, 1, BE_HALF, 0, 2'd0);
    @(negedge clk); drive(ld, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    drive('0, 32'h0, 1'b0, 32'h0);
    #1 chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_retired", retired, 0);
    chk("mid_rst_ready", ready, 1);
    exp_ret = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); drive('0, 32'h0, 1'b1, 32'h1234_5678);
    #2 chk("late_rsp_spurious", spur, 1);
    chk("late_rsp_wr_en", wr_en, 0);
    chk("late_rsp_ready", ready, 1);
    @(posedge clk); #1;
    chk("late_rsp_stall_cnt", stall_cnt, 0);
    chk("late_rsp_retired", retired, 0);
    chk("late_rsp_fwd_valid", fwd_valid, 0);

    // Stall counter saturation.
    ld = mk(1, SEL_DMEM, 1, 5'd16, 1, BE_WORD, 0, 2'd0);
    @(negedge clk); drive(ld, 32'h0, 1'b0, 32'h0);
    repeat (65540) @(posedge clk);
    #1 chk("sat_stall_cnt", stall_cnt, 32'h0000_FFFF);
    chk("sat_ready", ready, 0);
    @(negedge clk); drive(ld, 32'h0, 1'b1, 32'h0000_0042);
    #2 chk("sat_rsp_wr_en", wr_en, 1);
    exp_ret++;
    @(posedge clk); #1;
    chk("sat_hold_stall_cnt", stall_cnt, 32'h0000_FFFF);
    chk("sat_retired", retired, exp_ret);
    chk("sat_fwd_data", fwd_data, 32'h0000_0042);

    @(negedge clk); drive('0, 32'h0, 1'b0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv_wb.md
RV_WB -- requirements
Module: rv_wb

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit: the single clock.
REQ-002 SHALL have reset `rst`, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have `ctrl`, input, t_wb_ctrl, Q104H control. Fields:
- valid
- sel_wb
- rf_wr_en
- rd_addr[4:0]
- dmem_rd_en
- dmem_byte_en[3:0]
- dmem_sign_ext
- addr_lsb[1:0]
REQ-004 SHALL have `pre_wb_data_Q104H`, input, 32 bits: registered PC+4/ALU result from the memory-access stage.
REQ-005 SHALL have `dmem_rsp_valid_Q104H`, input, 1 bit: load data returned this cycle.
REQ-006 SHALL have `dmem_rsp_data_Q104H`, input, 32 bits: raw aligned 32-bit word from D_MEM.
REQ-007 SHALL have `ready_Q104H`, output, 1 bit: low stalls all upstream stages.
REQ-008 SHALL have register-file write port outputs `rf_wr_en_Q104H` (1), `rf_wr_addr_Q104H` (5) and `rf_wr_data_Q104H` (32).
REQ-009 SHALL have forwarding outputs `fwd_valid_Q105H` (1), `fwd_addr_Q105H` (5) and `fwd_data_Q105H` (32): last committed write, one cycle late.
REQ-010 SHALL have `misalign_err_Q104H`, output, 1 bit: one-cycle pulse on a misaligned load.
REQ-011 SHALL have `spurious_rsp_Q104H`, output, 1 bit: one-cycle pulse on a response that arrives with no load outstanding.
REQ-012 SHALL have `retired_cnt`, output, 32 bits: count of committed instructions.
REQ-013 SHALL have `ld_stall_cnt`, output, 16 bits: count of load-wait cycles.

Function
REQ-014 SHALL implement FSM states WB_IDLE and WB_WAIT.
REQ-015 In WB_IDLE, a valid load (`valid & dmem_rd_en`) without `dmem_rsp_valid` SHALL go to WB_WAIT and drive `ready_Q104H`=0 in that same cycle.
REQ-016 In WB_WAIT, `ready_Q104H` SHALL stay 0 and `ld_stall_cnt` SHALL increment each cycle, saturating at 0xFFFF, until `dmem_rsp_valid`. On `dmem_rsp_valid` it SHALL commit the load combinationally that cycle, assert ready, and return to WB_IDLE.
REQ-017 A load whose response arrives in its first Q104H cycle SHALL commit with zero stall cycles.
REQ-018 Load alignment SHALL shift `rsp_data` right by 8*`addr_lsb`. It SHALL then take the low 8 bits for byte_en 0001, 16 bits for 0011 and 32 bits for 1111. It SHALL sign-extend if `dmem_sign_ext`, otherwise zero-extend.
REQ-019 A load SHALL be misaligned when it is a half with `addr_lsb`=11, or a word with `addr_lsb`≠00. A misaligned load SHALL pulse `misalign_err`, suppress `rf_wr_en`, and still count as retired.
REQ-020 `rf_wr_data` SHALL be the aligned load data when sel_wb=SEL_DMEM, otherwise `pre_wb_data_Q104H`.
REQ-021 `rf_wr_en` SHALL be `valid & rf_wr_en & (rd_addr≠0) & commit`, where commit = ready, or the response cycle of a load. Writes to x0 are never issued.
REQ-022 The forwarding registers SHALL capture {1, addr, data} on every issued write and SHALL clear `fwd_valid` on a cycle with no issued write.
REQ-023 `retired_cnt` SHALL increment by 1 on each committed valid instruction and wrap at 2^32.
REQ-024 A `dmem_rsp_valid` in WB_IDLE with no load present SHALL be ignored, except for pulsing `spurious_rsp`.
REQ-025 When `valid`=0, no write SHALL be issued and no counter SHALL change, except `ld_stall_cnt` in WB_WAIT.

Reset
REQ-026 On `rst`=0, asynchronously: FSM=WB_IDLE; `fwd_valid`=0; `fwd_addr`=0; `fwd_data`=0; `retired_cnt`=0; `ld_stall_cnt`=0.
REQ-027 During reset, `ready_Q104H` SHALL be 1, and `rf_wr_en`, `misalign_err` and `spurious_rsp` SHALL be 0.
REQ-028 Reset asserted in WB_WAIT SHALL abandon the outstanding load. A response arriving after reset SHALL be treated as spurious.

Structure
REQ-029 `t_wb_ctrl`, the SEL_DMEM encoding of `t_wb_sel` and the byte-enable constants (BE_BYTE, BE_HALF, BE_WORD) SHALL live in rv_pkg.
REQ-030 Alignment and sign extension SHALL be a combinational sub-module `rv_ld_align`. The FSM and counters SHALL stay in rv_wb.
REQ-031 Flops SHALL use the async-reset DFF macros from dff_macros.svh.

Verification
REQ-032 ALU op writing x5 with `pre_wb_data`=0x1234 -> same cycle `rf_wr_en`=1, addr=5, data=0x1234; next cycle `fwd_valid`=1, `fwd_data`=0x1234.
REQ-033 LB with `addr_lsb`=2, sign_ext=1, rsp 0x0080_0000 one cycle after entry -> one stall cycle (`ready`=0), then write 0xFFFF_FF80; `ld_stall_cnt`=1.
REQ-034 LHU with `addr_lsb`=2, rsp 0xBEEF_0000 in the same cycle -> no stall, data 0x0000_BEEF.
REQ-035 LW with `addr_lsb`=1 -> `misalign_err` pulse, `rf_wr_en`=0, `retired_cnt` +1.
REQ-036 Load waiting for 3 cycles, `rst` pulsed on cycle 2, then rsp -> WB_IDLE immediately, `spurious_rsp`=1, no write, counters 0.
REQ-037 Write targeting x0 with data 0xFFFF_FFFF -> `rf_wr_en`=0, `fwd_valid`=0, `retired_cnt` +1.
